axis_frame_aligner: RTL and testbench
=====================================

// Module: axis_frame_aligner
// PURPOSE
// - Upstream conditioning stage in front of the barrel distortion corrector, which requires exact WIDTH x HEIGHT frames.
// - Locks onto SOF (tuser), then regenerates tuser and tlast from its own x/y counters.
// - Pads short lines and short frames with PAD_VALUE, and drops excess pixels on long lines.
// - Every emitted frame is exactly WIDTH x HEIGHT beats; the block has one registered output stage.
// PARAMETERS
// - WIDTH        1920      active pixels per line
// - HEIGHT       1080      active lines per frame
// - DATA_WIDTH   24        pixel width (RGB888)
// - COORD_WIDTH  16        x/y counter width
// - PAD_VALUE    24'h0     filler pixel value (DATA_WIDTH bits)
// PORTS
// - clk             in   1    single clock; everything is synchronous to it
// - rst             in   1    synchronous, active-high reset
// - s_axis_tdata    in   DW   input pixel
// - s_axis_tvalid   in   1    input beat valid
// - s_axis_tlast    in   1    input end of line
// - s_axis_tuser    in   1    input start of frame
// - s_axis_tready   out  1    input accept (combinational)
// - m_axis_tdata    out  DW   output pixel (registered)
// - m_axis_tvalid   out  1    output beat valid
// - m_axis_tlast    out  1    regenerated end of line (x == WIDTH-1)
// - m_axis_tuser    out  1    regenerated start of frame (x == 0, y == 0)
// - m_axis_tready   in   1    downstream accept
// - err_short_line  out  1    1-cycle pulse: tlast arrived before x == WIDTH-1
// - err_long_line   out  1    1-cycle pulse: no tlast at x == WIDTH-1
// - err_early_sof   out  1    1-cycle pulse: tuser arrived mid-frame
// - frame_count     out  16   completed output frames; wraps at 16'hFFFF -> 0
// BEHAVIOUR
// Reset
// - All m_axis_* outputs, err_* and frame_count are 0.
// - x = y = 0; state = WAIT_SOF.
// - Reset asserted mid-frame abandons the frame: m_axis_tvalid is 0 on the next cycle and no padding is emitted.
// Output register
// - ld = !m_axis_tvalid || m_axis_tready.
// - A beat loads only when ld is true.
// - m_axis_tvalid falls only when ld is true and no beat loads.
// - Input-to-output latency is 1 cycle.
// - An emitted beat carries tlast = (x == WIDTH-1) and tuser = (x == 0 && y == 0).
// - After each emitted beat, x advances; on wrap, y advances. Frame end is (x, y) = (WIDTH-1, HEIGHT-1).
// - On frame end: x = y = 0, frame_count is incremented, state = WAIT_SOF.
// States
// - WAIT_SOF
//   - s_axis_tready = ld.
//   - Beats with tuser = 0 are accepted and dropped.
//   - A beat with tuser = 1 is emitted as pixel (0,0), then state = PASS.
//   - A tuser beat that also has tlast set and WIDTH > 1 is handled as a short line: the beat is emitted and state = PAD_LINE.
// - PASS
//   - s_axis_tready = ld && !(s_axis_tvalid && s_axis_tuser).
//   - A valid beat with tuser = 1 is not accepted: pulse err_early_sof, state = PAD_FRAME.
//   - The held beat is accepted later, in WAIT_SOF.
//   - An accepted beat is emitted.
//   - Short line (tlast with x < WIDTH-1): pulse err_short_line, state = PAD_LINE.
//   - Long line (x == WIDTH-1 without tlast): pulse err_long_line, state = DISCARD.
//   - Frame end takes priority on the exit state; the error pulse still fires.
// - PAD_LINE
//   - s_axis_tready = 0.
//   - Emit PAD_VALUE on each ld through x == WIDTH-1.
//   - Then state = PASS, or WAIT_SOF if this was the frame end.
// - DISCARD
//   - Nothing is emitted; s_axis_tready = !s_axis_tuser.
//   - Beats are dropped until an accepted beat has tlast, then state = PASS.
//   - A tuser beat is not accepted and state = PASS, where it triggers the early-SOF path.
//   - Entry to DISCARD never occurs from the frame end; that case exits to WAIT_SOF, where excess beats drop as pre-SOF.
// - PAD_FRAME
//   - s_axis_tready = 0.
//   - Emit PAD_VALUE with correct tlast per line until the frame end, then state = WAIT_SOF.
// Widths and pulses
// - x and y are COORD_WIDTH bits.
// - frame_count is 16 bits, modulo 2^16.
// - Error pulses are registered and high for exactly 1 cycle per event.
// - Error pulses do not depend on m_axis_tready.
// TESTING (WIDTH=8, HEIGHT=4, PAD_VALUE=24'hABCDEF)
// - Clean frame of 32 beats, tuser on beat 0, tlast every 8th, m_axis_tready = 1:
//   - output is identical, delayed 1 cycle; frame_count = 1; no err pulses.
// - Line 1 has tlast at beat 5:
//   - 5 real + 3 beats 24'hABCDEF with tlast on the 8th;
//   - err_short_line pulses once; total output = 32 beats.
// - Line 2 has 11 beats:
//   - 8 emitted, 3 dropped, err_long_line once; line 3 starts with the 12th beat.
// - New tuser at line 2, x = 3:
//   - remaining 13 beats padded, err_early_sof once; the next frame starts with that tuser beat as (0,0).
// - Random m_axis_tready backpressure (50%) over 3 clean frames:
//   - no beat lost or duplicated, tdata stable while stalled, frame_count = 3.
// - Reset asserted at beat 20:
//   - m_axis_tvalid = 0 next cycle, frame_count = 0;
//   - 4 non-tuser beats are dropped, then the next tuser frame passes cleanly.

Source files
------------

// File: rtl/axis_frame_aligner_if.sv
// AXI4-Stream video bus used on both sides of axis_frame_aligner.
//   tdata  : pixel
//   tvalid : beat valid
//   tlast  : end of line
//   tuser  : start of frame
//   tready : sink accept
// The master modport drives the beat and samples tready; slave is the mirror.
interface axis_frame_aligner_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, tuser, input  tready);
  modport slave  (input  tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_aligner.sv
// Frame aligner in front of the barrel distortion corrector.
// Locks onto SOF, regenerates tuser/tlast from internal x/y counters, pads
// short lines and short frames with PAD_VALUE and drops the tail of long
// lines, so every emitted frame is exactly WIDTH x HEIGHT beats.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_axis          : input stream (slave); tready is combinational
//   m_axis          : output stream (master); one registered stage
//   err_short_line  : 1-cycle pulse, tlast seen before x == WIDTH-1
//   err_long_line   : 1-cycle pulse, no tlast at x == WIDTH-1
//   err_early_sof   : 1-cycle pulse, tuser seen mid-frame
//   frame_count     : completed output frames, modulo 2^16
module axis_frame_aligner #(
  parameter int                    WIDTH       = 1920,
  parameter int                    HEIGHT      = 1080,
  parameter int                    DATA_WIDTH  = 24,
  parameter int                    COORD_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  axis_frame_aligner_if.slave         s_axis,
  axis_frame_aligner_if.master        m_axis,
  output logic                        err_short_line,
  output logic                        err_long_line,
  output logic                        err_early_sof,
  output logic [15:0]                 frame_count
);

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    PAD_LINE,
    DISCARD,
    PAD_FRAME
  } state_t;

  localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);

  state_t                 state;
  logic [COORD_WIDTH-1:0] x;
  logic [COORD_WIDTH-1:0] y;

  logic ld;
  logic s_ready;
  logic accept;
  logic x_end;
  logic frame_end;
  logic sof_held;
  logic load_pixel;
  logic load_pad;
  logic pix_short;
  logic pix_long;

  // The output register may take a new beat when empty or being drained.
  assign ld        = !m_axis.tvalid || m_axis.tready;
  assign x_end     = (x == X_LAST);
  assign frame_end = x_end && (y == Y_LAST);
  assign sof_held  = s_axis.tvalid && s_axis.tuser;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      WAIT_SOF: s_ready = ld;
      // A mid-frame SOF is held off so it can open the next frame later.
      PASS:     s_ready = ld && !sof_held;
      DISCARD:  s_ready = !s_axis.tuser;
      default:  s_ready = 1'b0;
    endcase
  end

  assign s_axis.tready = s_ready;
  assign accept        = s_axis.tvalid && s_ready;

  // Real pixel: SOF beat in WAIT_SOF, or any accepted beat in PASS.
  assign load_pixel = accept && ((state == PASS) ||
                                 (state == WAIT_SOF && s_axis.tuser));
  assign load_pad   = ld && (state == PAD_LINE || state == PAD_FRAME);
  assign pix_short  = s_axis.tlast && !x_end;
  assign pix_long   = x_end && !s_axis.tlast;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_SOF;
      x              <= '0;
      y              <= '0;
      m_axis.tdata   <= '0;
      m_axis.tvalid  <= 1'b0;
      m_axis.tlast   <= 1'b0;
      m_axis.tuser   <= 1'b0;
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
      err_early_sof  <= 1'b0;
      frame_count    <= '0;
    end else begin
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
      err_early_sof  <= 1'b0;

      // Output stage and coordinate counters advance together on each beat.
      if (load_pixel || load_pad) begin
        m_axis.tdata  <= load_pixel ? s_axis.tdata : PAD_VALUE;
        m_axis.tvalid <= 1'b1;
        m_axis.tlast  <= x_end;
        m_axis.tuser  <= (x == '0) && (y == '0);
        if (frame_end) begin
          x           <= '0;
          y           <= '0;
          frame_count <= frame_count + 16'd1;
        end else if (x_end) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else if (ld) begin
        m_axis.tvalid <= 1'b0;
      end

      case (state)
        WAIT_SOF, PASS: begin
          if (state == PASS && sof_held) begin
            err_early_sof <= 1'b1;
            state         <= PAD_FRAME;
          end else if (load_pixel) begin
            err_short_line <= pix_short;
            err_long_line  <= pix_long;
            // Frame end wins the exit state; excess beats then drop as pre-SOF.
            if (frame_end)      state <= WAIT_SOF;
            else if (pix_short) state <= PAD_LINE;
            else if (pix_long)  state <= DISCARD;
            else                state <= PASS;
          end
        end
        PAD_LINE: begin
          if (load_pad && x_end) state <= frame_end ? WAIT_SOF : PASS;
        end
        DISCARD: begin
          // A SOF here is left pending so PASS raises the early-SOF path.
          if (sof_held)                    state <= PASS;
          else if (accept && s_axis.tlast) state <= PASS;
        end
        PAD_FRAME: begin
          if (load_pad && frame_end) state <= WAIT_SOF;
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_aligner.sv
// Self-checking bench for axis_frame_aligner with WIDTH=8, HEIGHT=4,
// PAD_VALUE=24'hABCDEF. A cycle-level vector table covers reset, latency,
// backpressure hold and the early-SOF handoff; hand-written frame sequences
// cover clean, short, long, early-SOF, random backpressure and mid-frame reset.
module tb_axis_frame_aligner;

  localparam int          W   = 8;
  localparam int          H   = 4;
  localparam int          DW  = 24;
  localparam logic [23:0] PAD = 24'hABCDEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tready_drv = 1'b1;
  logic        bp_en = 1'b0;
  logic        err_short_line;
  logic        err_long_line;
  logic        err_early_sof;
  logic [15:0] frame_count;

  axis_frame_aligner_if #(.DATA_WIDTH(DW)) s_if ();
  axis_frame_aligner_if #(.DATA_WIDTH(DW)) m_if ();

  axis_frame_aligner #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .COORD_WIDTH(16), .PAD_VALUE(PAD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_early_sof  (err_early_sof),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  // Downstream ready: either the directed value or a 50% random pattern.
  always @(posedge clk) begin
    #2;
    m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : tready_drv;
  end

  typedef struct packed {
    logic [23:0] data;
    logic        last;
    logic        user;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_short = 0;
  int n_long = 0;
  int n_early = 0;
  int stall_checks = 0;
  int stall_bad = 0;
  logic  stall_prev = 1'b0;
  beat_t stall_beat;

  // Output monitor: collects accepted beats, checks stall stability, counts pulses.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        stall_checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== stall_beat.data ||
            m_if.tlast !== stall_beat.last || m_if.tuser !== stall_beat.user)
          stall_bad++;
      end
      if (m_if.tvalid && m_if.tready)
        got.push_back('{m_if.tdata, m_if.tlast, m_if.tuser});
      stall_prev = m_if.tvalid && !m_if.tready;
      stall_beat = '{m_if.tdata, m_if.tlast, m_if.tuser};
      if (err_short_line) n_short++;
      if (err_long_line)  n_long++;
      if (err_early_sof)  n_early++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] lb(input int t, input int l);
    return {8'(t), 8'(l), 8'h00};
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [23:0] d, input logic l, input logic u);
    int  n = 0;
    bit  done = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = s_if.tready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n >= 300) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: beat 0x%0h not accepted after %0d cycles", d, n);
        done = 1'b1;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_line(input logic [23:0] base, input int n, input bit sof, input bit tl);
    for (int i = 0; i < n; i++)
      send_beat(base + 24'(i), tl && (i == n - 1), sof && (i == 0));
  endtask

  task automatic exp_line(input logic [23:0] base, input int nreal, input bit sof);
    for (int x = 0; x < W; x++)
      exp_q.push_back('{(x < nreal) ? base + 24'(x) : PAD, x == W - 1, sof && (x == 0)});
  endtask

  task automatic send_clean_frame(input int t);
    for (int l = 0; l < H; l++) send_line(lb(t, l), W, l == 0, 1'b1);
  endtask

  task automatic exp_clean_frame(input int t);
    for (int l = 0; l < H; l++) exp_line(lb(t, l), W, l == 0);
  endtask

  task automatic wait_out(input int base);
    int c = 0;
    while ((got.size() - base) < exp_q.size() && c < 2000) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string name, input int base);
    check({name, "_beats"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got.size())
        check($sformatf("%s[%0d]", name, i), 32'(got[base + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_errs(input string name, input int s0, input int l0, input int e0,
                            input int ds, input int dl, input int de);
    check({name, "_err_short"}, 32'(n_short - s0), 32'(ds));
    check({name, "_err_long"},  32'(n_long - l0),  32'(dl));
    check({name, "_err_early"}, 32'(n_early - e0), 32'(de));
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        valid;
    logic        last;
    logic        user;
    logic [23:0] data;
    logic        rdy;
    logic        exp_sready;
    logic        exp_mvalid;
    logic [23:0] exp_mdata;
    logic        exp_mlast;
    logic        exp_muser;
    logic [2:0]  exp_err;   // {short, long, early}
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, s0, l0, e0;

    // Outputs observed in a row are the result of the previous row's inputs.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 24'h000011, 1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 24'h000100, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 3'b000};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 24'h000101, 1'b0, 1'b0, 1'b1, 24'h000100, 1'b0, 1'b1, 3'b000};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 24'h000101, 1'b1, 1'b1, 1'b1, 24'h000100, 1'b0, 1'b1, 3'b000};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b1, 24'h000101, 1'b0, 1'b0, 3'b000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 24'h000200, 1'b1, 1'b0, 1'b0, 24'h000101, 1'b0, 1'b0, 3'b000};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 24'h000200, 1'b1, 1'b0, 1'b0, 24'h000101, 1'b0, 1'b0, 3'b001};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 24'h000200, 1'b1, 1'b0, 1'b1, PAD,        1'b0, 1'b0, 3'b000};

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_mvalid", 32'(m_if.tvalid), 32'd0);
    check("reset_mdata",  32'(m_if.tdata),  32'd0);
    check("reset_mlast_muser", 32'({m_if.tlast, m_if.tuser}), 32'd0);
    check("reset_err", 32'({err_short_line, err_long_line, err_early_sof}), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);

    for (int i = 0; i < 8; i++) begin
      s_if.tvalid = tbl[i].valid;
      s_if.tlast  = tbl[i].last;
      s_if.tuser  = tbl[i].user;
      s_if.tdata  = tbl[i].data;
      tready_drv  = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_sready", i), 32'(s_if.tready), 32'(tbl[i].exp_sready));
      check($sformatf("vec%0d_mvalid", i), 32'(m_if.tvalid), 32'(tbl[i].exp_mvalid));
      check($sformatf("vec%0d_mdata", i),  32'(m_if.tdata),  32'(tbl[i].exp_mdata));
      check($sformatf("vec%0d_mlast_muser", i), 32'({m_if.tlast, m_if.tuser}),
            32'({tbl[i].exp_mlast, tbl[i].exp_muser}));
      check($sformatf("vec%0d_err", i), 32'({err_short_line, err_long_line, err_early_sof}),
            32'(tbl[i].exp_err));
      @(posedge clk);
      #1;
    end
    tready_drv = 1'b1;
    do_reset();

    // Clean frame passes through unchanged.
    base = got.size(); s0 = n_short; l0 = n_long; e0 = n_early;
    send_clean_frame(0);
    exp_clean_frame(0);
    wait_out(base);
    compare_out("clean", base);
    check("clean_frame_count", 32'(frame_count), 32'd1);
    check_errs("clean", s0, l0, e0, 0, 0, 0);

    // Line 1 ends after 5 beats: 3 pad beats complete it.
    base = got.size(); s0 = n_short; l0 = n_long; e0 = n_early;
    send_line(lb(1, 0), 8, 1'b1, 1'b1);
    send_line(lb(1, 1), 5, 1'b0, 1'b1);
    send_line(lb(1, 2), 8, 1'b0, 1'b1);
    send_line(lb(1, 3), 8, 1'b0, 1'b1);
    exp_line(lb(1, 0), 8, 1'b1);
    exp_line(lb(1, 1), 5, 1'b0);
    exp_line(lb(1, 2), 8, 1'b0);
    exp_line(lb(1, 3), 8, 1'b0);
    wait_out(base);
    compare_out("short", base);
    check("short_frame_count", 32'(frame_count), 32'd2);
    check_errs("short", s0, l0, e0, 1, 0, 0);

    // Line 2 has 11 beats: the last 3 are dropped.
    base = got.size(); s0 = n_short; l0 = n_long; e0 = n_early;
    send_line(lb(2, 0), 8, 1'b1, 1'b1);
    send_line(lb(2, 1), 8, 1'b0, 1'b1);
    send_line(lb(2, 2), 11, 1'b0, 1'b1);
    send_line(lb(2, 3), 8, 1'b0, 1'b1);
    exp_line(lb(2, 0), 8, 1'b1);
    exp_line(lb(2, 1), 8, 1'b0);
    exp_line(lb(2, 2), 8, 1'b0);
    exp_line(lb(2, 3), 8, 1'b0);
    wait_out(base);
    compare_out("long", base);
    check("long_frame_count", 32'(frame_count), 32'd3);
    check_errs("long", s0, l0, e0, 0, 1, 0);

    // New SOF at line 2, x = 3: 13 pad beats, then the new frame from that SOF.
    base = got.size(); s0 = n_short; l0 = n_long; e0 = n_early;
    send_line(lb(3, 0), 8, 1'b1, 1'b1);
    send_line(lb(3, 1), 8, 1'b0, 1'b1);
    send_line(lb(3, 2), 3, 1'b0, 1'b0);
    send_clean_frame(4);
    exp_line(lb(3, 0), 8, 1'b1);
    exp_line(lb(3, 1), 8, 1'b0);
    exp_line(lb(3, 2), 3, 1'b0);
    exp_line(lb(3, 3), 0, 1'b0);
    exp_clean_frame(4);
    wait_out(base);
    compare_out("early_sof", base);
    check("early_sof_frame_count", 32'(frame_count), 32'd5);
    check_errs("early_sof", s0, l0, e0, 0, 0, 1);

    // Three clean frames under random downstream backpressure.
    base = got.size(); s0 = n_short; l0 = n_long; e0 = n_early;
    bp_en = 1'b1;
    for (int f = 5; f < 8; f++) begin
      send_clean_frame(f);
      exp_clean_frame(f);
    end
    bp_en = 1'b0;
    wait_out(base);
    compare_out("backpressure", base);
    check("backpressure_frame_count", 32'(frame_count), 32'd8);
    check_errs("backpressure", s0, l0, e0, 0, 0, 0);
    check("stall_seen", 32'(stall_checks > 0), 32'd1);
    check("stall_hold_violations", 32'(stall_bad), 32'd0);

    // Reset at beat 20 abandons the frame; pre-SOF beats are then dropped.
    for (int k = 0; k < 20; k++)
      send_beat(lb(8, k / W) + 24'(k % W), (k % W) == W - 1, k == 0);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_mvalid", 32'(m_if.tvalid), 32'd0);
    check("midreset_frame_count", 32'(frame_count), 32'd0);
    rst = 1'b0;
    base = got.size(); s0 = n_short; l0 = n_long; e0 = n_early;
    for (int k = 0; k < 4; k++) send_beat(24'h0F0000 + 24'(k), 1'b0, 1'b0);
    send_clean_frame(9);
    exp_clean_frame(9);
    wait_out(base);
    compare_out("after_reset", base);
    check("after_reset_frame_count", 32'(frame_count), 32'd1);
    check_errs("after_reset", s0, l0, e0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
